spike_tick_logger: RTL and testbench
====================================

SPIKE_TICK_LOGGER -- requirements
Module: spike_tick_logger

Interface
REQ-001 Parameter DEPTH, default 512, FIFO depth in records; power of two, minimum 4.
REQ-002 Parameter CNT_W, default 16, width of the per-window spike count and of the timestamp.
REQ-003 clk  input  1  single clock, the raw board clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 spike  input  1  raw neuron spike level, synchronous to clk; may stay high for several cycles.
REQ-006 tick  input  1  one-cycle strobe marking the end of each 1 ms simulation step.
REQ-007 enable  input  1  high = count spikes and log records; low = no logging.
REQ-008 rd_en  input  1  pop request from the host pipe-out side.
REQ-009 dout  output  32  head record, first-word-fall-through.
REQ-010 empty  output  1  FIFO holds no records.
REQ-011 full  output  1  FIFO holds DEPTH records.
REQ-012 level  output  log2(DEPTH)+1  number of records held.
REQ-013 overflow  output  1  sticky flag: at least one record has been dropped.
REQ-014 drop_cnt  output  16  number of dropped records, saturating at 16'hFFFF.

Function
REQ-015 Spike counting: a rising edge on spike is a 0->1 change between consecutive clk samples; each edge adds 1 to the window counter, which saturates at 2^CNT_W-1.
REQ-016 Window close: on a cycle with tick=1 and enable=1, a record {timestamp, window_count} is pushed, and the window counter loads 1 if that cycle has a rising edge, else 0.
REQ-017 A spike edge coinciding with tick belongs to the new window, not to the record being pushed.
REQ-018 The timestamp increments by 1 (mod 2^CNT_W) on every tick, whatever the state of enable; the pushed record carries the value before the increment.
REQ-019 With enable=0: the window counter holds 0, no push occurs, and edge detection keeps running.
REQ-020 Push latency: the record is visible on dout, and empty deasserts, on the cycle after the tick cycle.
REQ-021 Pop: rd_en=1 with empty=0 removes the head record, and the next record appears on dout on the following cycle; rd_en with empty=1 is ignored and causes no underflow.
REQ-022 Simultaneous push and pop when full: the pop succeeds, the push is accepted, and level stays DEPTH.
REQ-023 Simultaneous push and pop when empty: the push is accepted, the pop is ignored, and level becomes 1.
REQ-024 Push when full with no pop: the record is dropped, overflow sets, and drop_cnt increments; FIFO contents are unchanged.
REQ-025 Pointers wrap modulo DEPTH; level counts 0..DEPTH exactly.
REQ-026 dout is undefined-but-stable (holds its last value) while empty=1.

Reset
REQ-027 reset=1 clears the FIFO pointers, level, window counter, timestamp, edge register, overflow and drop_cnt; after reset, empty=1, full=0, and dout=0.
REQ-028 Reset mid-operation discards all stored and partial records; a tick or rd_en on the reset cycle is ignored.

Configuration
REQ-029 Macro SPIKE_LOGGER_TIMESTAMP_EN controls the timestamp.
REQ-030 With the macro defined, a record is {timestamp[15:0], count[15:0]}.
REQ-031 Without the macro, a record is {16'h0000, count[15:0]}, the timestamp counter is not synthesised, and all other behaviour is identical.

Structure
REQ-032 A shared package holds the record width (32), the record field offsets, the default DEPTH, and the drop-counter width.
REQ-033 The storage is a sub-module sync_fifo (FWFT, single clock, BRAM-inferable); the window counter, edge detect, timestamp and overflow logic live in spike_tick_logger.

Verification
REQ-034 Three spike pulses, each 4 cycles wide, then one tick with enable=1 -> one record, count=3, timestamp=0, appearing one cycle after the tick.
REQ-035 A spike rising edge on the same cycle as the tick -> the closing record omits it, and the next record counts it (count=1 with no further spikes).
REQ-036 With DEPTH=4, six ticks and no reads -> full=1, level=4, overflow=1, drop_cnt=2; reading four records returns timestamps 0,1,2,3.
REQ-037 rd_en held high with the FIFO empty for 10 cycles, then one tick -> level never goes negative, and the record appears with level=1.
REQ-038 enable=0 for 5 ticks, then enable=1 and one tick -> one record with timestamp=5 (without the macro: upper half 0).
REQ-039 Reset asserted with level=3 and a partially counted window -> the next cycle shows empty=1, overflow=0, and the next record has timestamp 0 and count 0.

Source files
------------

// File: rtl/spike_tick_logger_pkg.sv
// Shared constants and record packing for the spike tick logger.
// Record layout: {timestamp[15:0], count[15:0]}.
package spike_tick_logger_pkg;

    localparam int REC_W         = 32;
    localparam int FIELD_W       = 16;
    localparam int CNT_LSB       = 0;
    localparam int TS_LSB        = 16;
    localparam int DEFAULT_DEPTH = 512;
    localparam int DROP_W        = 16;

    function automatic logic [REC_W-1:0] pack_record(input logic [FIELD_W-1:0] ts,
                                                     input logic [FIELD_W-1:0] cnt);
        logic [REC_W-1:0] rec;
        rec = '0;
        rec[TS_LSB +: FIELD_W]  = ts;
        rec[CNT_LSB +: FIELD_W] = cnt;
        return rec;
    endfunction

endpackage

// File: rtl/spike_tick_logger_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head word.
// Storage array has no reset so it can map onto block RAM.
module sync_fifo
    import spike_tick_logger_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_DEPTH,
    parameter int  WIDTH = REC_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic             push;
    logic             pop;

    assign empty      = (level == '0);
    assign full       = (level == (AW+1)'(DEPTH));
    assign pop        = rd_en & ~empty;
    // A pop on a full FIFO frees the slot the write lands in.
    assign push       = wr_en & (~full | rd_en);
    assign rd_ptr_nxt = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
            // Head register: bypass new data when it becomes the head, else prefetch.
            if ((empty && push) || (pop && push && level == (AW+1)'(1))) begin
                dout <= din;
            end else if (pop && level > (AW+1)'(1)) begin
                dout <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/spike_tick_logger.sv
// Counts spike rising edges per tick window and logs {timestamp, count} records.
// Define SPIKE_LOGGER_TIMESTAMP_EN to include the timestamp counter in records.
module spike_tick_logger
    import spike_tick_logger_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     spike,
    input  logic                     tick,
    input  logic                     enable,
    input  logic                     rd_en,
    output logic [REC_W-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt
);

    logic               spike_q;
    logic               spike_rise;
    logic [CNT_W-1:0]   win_cnt;
    logic               push_req;
    logic               drop;
    logic [FIELD_W-1:0] ts_field;
    logic [REC_W-1:0]   record;

    assign spike_rise = spike & ~spike_q;
    assign push_req   = tick & enable;
    assign drop       = push_req & full & ~rd_en;

`ifdef SPIKE_LOGGER_TIMESTAMP_EN
    logic [CNT_W-1:0] timestamp;

    always_ff @(posedge clk) begin
        if (reset) begin
            timestamp <= '0;
        end else if (tick) begin
            timestamp <= timestamp + 1'b1;
        end
    end

    assign ts_field = FIELD_W'(timestamp);
`else
    assign ts_field = '0;
`endif

    assign record = pack_record(ts_field, FIELD_W'(win_cnt));

    always_ff @(posedge clk) begin
        if (reset) begin
            spike_q <= 1'b0;
        end else begin
            spike_q <= spike;
        end
    end

    // An edge on the tick cycle opens the next window rather than closing this one.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            win_cnt <= '0;
        end else if (tick) begin
            win_cnt <= CNT_W'(spike_rise);
        end else if (spike_rise && win_cnt != '1) begin
            win_cnt <= win_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (push_req),
        .din   (record),
        .rd_en (rd_en),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .level (level)
    );

endmodule

// File: tb/tb_spike_tick_logger.sv
// Scoreboard bench for spike_tick_logger with DEPTH=4; expected records queued at tick time.
module tb_spike_tick_logger;
    import spike_tick_logger_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        spike;
    logic        tick;
    logic        enable;
    logic        rd_en;
    logic [31:0] dout;
    logic        empty;
    logic        full;
    logic [2:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;

    int          total;
    int          bad;
    int          exp_drops;
    logic [15:0] ts_model;
    logic [31:0] exp_q [$];

    spike_tick_logger #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .spike    (spike),
        .tick     (tick),
        .enable   (enable),
        .rd_en    (rd_en),
        .dout     (dout),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rec(input logic [15:0] ts, input logic [15:0] cnt);
`ifdef SPIKE_LOGGER_TIMESTAMP_EN
        return {ts, cnt};
`else
        return {16'h0000, cnt};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must present the oldest expected record.
    always @(negedge clk) begin
        if (!reset && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got %h expected no record", dout);
            end else begin
                check("pop_data", dout, exp_q.pop_front());
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        next();
        reset     = 1'b0;
        ts_model  = '0;
        exp_drops = 0;
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            spike = 1'b1;
            repeat (4) next();
            spike = 1'b0;
            repeat (2) next();
        end
    endtask

    task automatic do_tick(input logic [15:0] cnt);
        if (enable) begin
            if (exp_q.size() < DEPTH || (rd_en && exp_q.size() > 0))
                exp_q.push_back(exp_rec(ts_model, cnt));
            else
                exp_drops++;
        end
        ts_model = ts_model + 16'd1;
        tick = 1'b1;
        next();
        tick = 1'b0;
    endtask

    task automatic read_all();
        int n;
        n = exp_q.size();
        rd_en = 1'b1;
        repeat (n) next();
        rd_en = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; exp_drops = 0; ts_model = '0;
        reset = 1'b1; spike = 1'b0; tick = 1'b0; enable = 1'b1; rd_en = 1'b0;
        next();
        do_reset();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_dout", dout, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);

        // Three 4-cycle pulses then a tick: count 3, ts 0, visible next cycle.
        pulses(3);
        do_tick(16'd3);
        check("t1_empty", empty, 0);
        check("t1_level", level, 1);
        check("t1_dout", dout, exp_rec(16'd0, 16'd3));
        read_all();
        check("t1_drained", empty, 1);
        check("t1_dout_hold", dout, exp_rec(16'd0, 16'd3));

        // Edge on the tick cycle belongs to the next window.
        spike = 1'b1;
        do_tick(16'd0);
        repeat (3) next();
        spike = 1'b0;
        next();
        do_tick(16'd1);
        check("t2_level", level, 2);
        read_all();

        // Reads on an empty FIFO are ignored, then push+pop on empty.
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            next();
            check("t3_level_zero", level, 0);
            check("t3_empty", empty, 1);
        end
        do_tick(16'd0);
        check("t3_level_one", level, 1);
        next();
        rd_en = 1'b0;
        check("t3_empty_after", empty, 1);

        // Disabled ticks advance the timestamp but push nothing.
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulses(1);
            do_tick(16'd0);
            check("t4_no_push", empty, 1);
        end
        enable = 1'b1;
        next();
        do_tick(16'd0);
        check("t4_level", level, 1);
        check("t4_dout", dout, exp_rec(16'd5, 16'd0));
        read_all();

        // Overflow with DEPTH=4: six ticks, no reads.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            pulses(i + 1);
            do_tick(16'(i + 1));
        end
        check("t5_full", full, 1);
        check("t5_level", level, 4);
        check("t5_overflow", overflow, 1);
        check("t5_drop_cnt", drop_cnt, 32'(exp_drops));
        check("t5_drop_cnt_two", drop_cnt, 2);
        read_all();
        check("t5_empty", empty, 1);
        for (int i = 0; i < 4; i++) do_tick(16'd0);
        check("t5_refull", full, 1);
        rd_en = 1'b1;
        do_tick(16'd0);
        rd_en = 1'b0;
        check("t5_pushpop_level", level, 4);
        check("t5_pushpop_full", full, 1);
        check("t5_pushpop_drops", drop_cnt, 2);

        // Reset with level 3 and a partial window.
        rd_en = 1'b1;
        next();
        rd_en = 1'b0;
        check("t6_level3", level, 3);
        pulses(2);
        reset = 1'b1; tick = 1'b1; rd_en = 1'b1;
        exp_q.delete();
        next();
        reset = 1'b0; tick = 1'b0; rd_en = 1'b0;
        ts_model = '0;
        check("t6_empty", empty, 1);
        check("t6_overflow", overflow, 0);
        check("t6_drop_cnt", drop_cnt, 0);
        check("t6_level", level, 0);
        check("t6_dout", dout, 0);
        do_tick(16'd0);
        check("t6_rec_level", level, 1);
        check("t6_rec_dout", dout, exp_rec(16'd0, 16'd0));
        read_all();
        next();
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
